// File: rtl/prog_div_pkg.sv
// Shared types, defaults and ratio helpers for the programmable clock divider.
package prog_div_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 2;

    // Output path selection, derived from the active ratio.
    typedef enum logic [1:0] {
        MODE_EVEN,
        MODE_ODD,
        MODE_BYPASS
    } div_mode_e;

    // A requested ratio of zero is meaningless; treat it as divide-by-one.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio == 32'd0) ? 32'd1 : ratio;
    endfunction

    // Number of whole cycles pos_q stays high in one output period: ceil(N/2).
    function automatic logic [31:0] half_hi(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/prog_div_if.sv
// Ratio request/acknowledge bus between a controller and the clock divider.
interface prog_div_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] div_ratio;
    logic             div_load;
    logic             div_ack;
    logic [CNT_W-1:0] cur_ratio;

    modport master (output div_ratio, div_load, input  div_ack, cur_ratio);
    modport slave  (input  div_ratio, div_load, output div_ack, cur_ratio);
endinterface

// File: rtl/div_odd_phase.sv
// Half-cycle stage and output mux: negedge copy of pos_q for odd ratios,
// straight pos_q for even ratios, and the raw clock in divide-by-one mode.
module div_odd_phase
    import prog_div_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      run_i,
    input  logic      pos_i,
    input  div_mode_e mode_i,
    output logic      clk_out_o
);

    logic neg_q;

    // Re-time pos_q onto the falling edge to get half-cycle resolution.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_i;
        end
    end

    // Select the output waveform; everything is held low while in reset.
    // NOTE: the output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        clk_out_o = 1'b0;
        unique case (mode_i)
            MODE_BYPASS: clk_out_o = clk & run_i;
            MODE_ODD:    clk_out_o = pos_i & neg_q;
            default:     clk_out_o = pos_i;
        endcase
        if (rst) begin
            clk_out_o = 1'b0;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty for any ratio,
// glitch-free ratio switching at period boundaries and a per-period enable pulse.
module prog_clk_divider
    import prog_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    prog_div_if.slave  ctrl,
    output logic       clk_out,
    output logic       clk_en
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t ONE      = cnt_t'(1);
    localparam cnt_t DEF_RATE = cnt_t'(DEFAULT_DIV);

    cnt_t      cnt_q, cnt_d;
    cnt_t      cur_q, cur_d;
    cnt_t      pend_q, pend_d;
    logic      pend_vld_q, pend_vld_d;
    logic      pos_q, pos_d;
    logic      en_q, en_d;
    logic      ack_q, ack_d;
    logic      run_q, run_d;

    logic      boundary;
    logic      apply;
    cnt_t      cnt_nxt;
    cnt_t      ratio_nxt;
    div_mode_e mode;

    // Next-state: period counter, ratio hand-over at the last cycle of a period, request capture.
    always_comb begin
        run_d      = 1'b1;
        boundary   = run_q && (cnt_q == (cur_q - ONE));
        apply      = boundary && pend_vld_q;
        ratio_nxt  = apply ? pend_q : cur_q;

        if (!run_q || boundary) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + ONE;
        end

        cnt_d      = cnt_nxt;
        cur_d      = ratio_nxt;
        pos_d      = (32'(cnt_nxt) < half_hi(32'(ratio_nxt)));
        en_d       = (cnt_nxt == '0);
        ack_d      = apply;

        // A pending ratio consumed this edge is replaced by a request arriving on the same edge.
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q && !apply;
        if (ctrl.div_load) begin
            pend_d     = cnt_t'(clamp_ratio(32'(ctrl.div_ratio)));
            pend_vld_d = 1'b1;
        end
    end

    // State registers; reset aborts the current period and drops any pending ratio.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            cur_q      <= DEF_RATE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            pos_q      <= 1'b0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pos_q      <= pos_d;
            en_q       <= en_d;
            ack_q      <= ack_d;
        end
    end

    // Output path follows the active ratio; it only changes at a period start.
    always_comb begin
        mode = MODE_EVEN;
        if (cur_q == ONE) begin
            mode = MODE_BYPASS;
        end else if (cur_q[0]) begin
            mode = MODE_ODD;
        end
    end

    div_odd_phase u_phase (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run_q),
        .pos_i     (pos_q),
        .mode_i    (mode),
        .clk_out_o (clk_out)
    );

    assign clk_en         = en_q;
    assign ctrl.div_ack   = ack_q;
    assign ctrl.cur_ratio = cur_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised and directed bench for prog_clk_divider with a period-level reference model.
module tb_prog_clk_divider;

    localparam int W   = 8;
    localparam int DEF = 2;

    logic clk = 1'b0;
    logic rst;
    logic clk_out;
    logic clk_en;

    prog_div_if #(.CNT_W(W)) bus ();

    prog_clk_divider #(.CNT_W(W), .DEFAULT_DIV(DEF)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (bus),
        .clk_out (clk_out),
        .clk_en  (clk_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    logic last_ack;

    // Reference model: position inside the current output period and ratio bookkeeping.
    int m_n = DEF;
    int m_k = 0;
    int m_pend = 0;
    bit m_run = 0;
    bit m_pend_vld = 0;
    bit m_ack = 0;
    bit m_after_bypass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected clk_out in half-cycle slot h (0 = first half of the period's first cycle).
    // Even N: high for the first N half-slots. Odd N: high N half-slots starting
    // half a cycle late, except right after bypass where the rising edge is kept.
    function automatic logic exp_out(input int h);
        if (rst || !m_run) return 1'b0;
        if (m_n == 1) return (h % 2) == 0;
        if (m_n % 2 == 0) return h < m_n;
        return (h >= 1 && h <= m_n) || (h == 0 && m_after_bypass);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_k = 0; m_n = DEF; m_pend_vld = 0; m_ack = 0; m_after_bypass = 0;
        end else begin
            m_ack = 0;
            if (!m_run) begin
                m_run = 1;
                m_k   = 0;
            end else if (m_k == m_n - 1) begin
                m_after_bypass = (m_n == 1);
                if (m_pend_vld) begin
                    m_n = m_pend; m_pend_vld = 0; m_ack = 1;
                end
                m_k = 0;
            end else begin
                m_k++;
            end
            if (bus.div_load) begin
                m_pend     = (bus.div_ratio == 0) ? 1 : int'(bus.div_ratio);
                m_pend_vld = 1;
            end
        end
    endtask

    // One clk cycle: update model at the edge, check both halves of the cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        check("clk_out_hi_half", 32'(clk_out), 32'(exp_out(2 * m_k)));
        check("clk_en", 32'(clk_en), 32'(m_run && m_k == 0));
        check("div_ack", 32'(bus.div_ack), 32'(m_ack));
        check("cur_ratio", 32'(bus.cur_ratio), 32'(m_n));
        last_ack = bus.div_ack;
        if (bus.div_ack === 1'b1) ack_cnt++;
        @(negedge clk);
        #2;
        check("clk_out_lo_half", 32'(clk_out), 32'(exp_out(2 * m_k + 1)));
    endtask

    task automatic do_load(input int ratio);
        bus.div_load  = 1'b1;
        bus.div_ratio = W'(ratio);
        step();
        bus.div_load  = 1'b0;
        bus.div_ratio = W'($urandom);
    endtask

    task automatic wait_ack(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = last_ack;
        end
        check("ack_arrives", 32'(seen), 32'd1);
    endtask

    task automatic wait_k(input int k, input int budget);
        bit hit;
        hit = (m_k == k);
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            hit = (m_k == k);
        end
        check("reach_phase", 32'(hit), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.div_load  = 1'b0;
        bus.div_ratio = '0;

        // Reset, then default ratio of 2.
        repeat (4) step();
        rst = 1'b0;
        repeat (6) step();

        // Divide by 4.
        do_load(4);
        wait_ack(20);
        repeat (10) step();

        // Divide by 3: half-cycle duty.
        do_load(3);
        wait_ack(20);
        repeat (9) step();

        // Zero clamps to bypass, then leave bypass to an odd ratio.
        do_load(0);
        wait_ack(20);
        repeat (4) step();
        check("cur_bypass", 32'(bus.cur_ratio), 32'd1);
        do_load(5);
        wait_ack(20);
        repeat (12) step();

        // Two loads within one period of 8: last wins, single acknowledge.
        do_load(8);
        wait_ack(20);
        step();
        do_load(6);
        step();
        do_load(10);
        ack_cnt = 0;
        repeat (20) step();
        check("single_ack", 32'(ack_cnt), 32'd1);
        check("cur_after_two_loads", 32'(bus.cur_ratio), 32'd10);

        // Reset mid-period with a ratio pending.
        do_load(7);
        wait_ack(30);
        do_load(3);
        wait_k(4, 20);
        rst = 1'b1;
        repeat (3) step();
        check("cur_in_reset", 32'(bus.cur_ratio), 32'(DEF));
        rst = 1'b0;
        ack_cnt = 0;
        repeat (20) step();
        check("no_ack_after_rst", 32'(ack_cnt), 32'd0);

        // Random loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.div_load  = 1'b1;
                bus.div_ratio = W'($urandom_range(0, 12));
            end else begin
                bus.div_load  = 1'b0;
                bus.div_ratio = W'($urandom);
            end
            step();
        end
        rst          = 1'b0;
        bus.div_load = 1'b0;
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
